// File: rtl/pow_pkg.sv
// Shared types and constants for the round-robin power arbiter and its engine.
package pow_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } arb_state_t;

  localparam logic READY = 1'b0;
  localparam logic BUSY  = 1'b1;

  // Selector width sized for the largest legal requester count so any N fits.
  localparam int N_MAX = 8;
  localparam int IW    = $clog2(N_MAX);

endpackage

// File: rtl/pow_engine.sv
// Iterative square-and-multiply engine computing inx^inn mod 2^XW, one step per cycle.
module pow_engine
  import pow_pkg::*;
#(
  parameter int XW = 16,
  parameter int NW = 8
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic          start,
  input  logic [XW-1:0] inx,
  input  logic [NW-1:0] inn,
  output logic          ready,
  output logic [XW-1:0] out
);

  logic          state;
  logic [XW-1:0] xr;
  logic [NW-1:0] nr;
  logic [XW-1:0] acc;

  // start is only honoured while ready; a start in BUSY is dropped.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state <= READY;
      xr    <= '0;
      nr    <= '0;
      acc   <= '0;
      out   <= '0;
    end else begin
      case (state)
        READY: begin
          if (start) begin
            xr    <= inx;
            nr    <= inn;
            acc   <= XW'(1);
            state <= BUSY;
          end
        end
        default: begin
          if (nr == '0) begin
            out   <= acc;
            state <= READY;
          end else if (nr[0]) begin
            acc <= acc * xr;
            nr  <= nr - 1'b1;
          end else begin
            xr <= xr * xr;
            nr <= nr >> 1;
          end
        end
      endcase
    end
  end

  assign ready = (state == READY);

endmodule

// File: rtl/pow_arbiter.sv
// Round-robin scheduler sharing one pow_engine among N requesters; one job at a time.
module pow_arbiter
  import pow_pkg::*;
#(
  parameter int N  = 4,
  parameter int XW = 16,
  parameter int NW = 8
) (
  input  logic            clk,
  input  logic            nrst,
  input  logic [N-1:0]    req,
  input  logic [N*XW-1:0] x_in,
  input  logic [N*NW-1:0] n_in,
  output logic [N-1:0]    gnt,
  output logic [N-1:0]    done,
  output logic [XW-1:0]   res,
  output logic            busy
);

  arb_state_t    state, state_nxt;
  logic [IW-1:0] ptr;
  logic [IW-1:0] sel;
  logic          eng_start;
  logic          eng_ready;
  logic [XW-1:0] eng_x;
  logic [XW-1:0] eng_out;
  logic [NW-1:0] eng_n;

  // Offsets scanned from farthest to nearest so the nearest requester to ptr wins.
  function automatic logic [IW-1:0] rr_pick(input logic [N-1:0] r, input logic [IW-1:0] p);
    int idx;
    rr_pick = p;
    for (int i = N - 1; i >= 0; i--) begin
      idx = (int'(p) + i) % N;
      if (((r >> idx) & N'(1)) != '0) rr_pick = IW'(idx);
    end
  endfunction

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|req) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (eng_ready) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state <= IDLE;
      ptr   <= '0;
      sel   <= '0;
      res   <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && |req) sel <= rr_pick(req, ptr);
      if (state == WAIT && eng_ready) res <= eng_out;
      if (state == DONE) ptr <= (int'(sel) >= N - 1) ? '0 : sel + 1'b1;
    end
  end

  always_comb begin
    eng_x = '0;
    eng_n = '0;
    for (int i = 0; i < N; i++) begin
      if (sel == IW'(i)) begin
        eng_x = x_in[i*XW +: XW];
        eng_n = n_in[i*NW +: NW];
      end
    end
  end

  assign eng_start = (state == ISSUE);
  assign busy      = (state != IDLE);
  assign gnt       = busy ? (N'(1) << sel) : '0;
  assign done      = (state == DONE) ? (N'(1) << sel) : '0;

  pow_engine #(.XW(XW), .NW(NW)) u_engine (
    .clk   (clk),
    .nrst  (nrst),
    .start (eng_start),
    .inx   (eng_x),
    .inn   (eng_n),
    .ready (eng_ready),
    .out   (eng_out)
  );

endmodule

// File: tb/tb_pow_arbiter.sv
// Scoreboard bench for pow_arbiter: expected {requester, latency, result} queued at drive time.
module tb_pow_arbiter;

  localparam int N  = 4;
  localparam int XW = 16;
  localparam int NW = 8;

  logic            clk = 1'b0;
  logic            nrst;
  logic [N-1:0]    req;
  logic [N*XW-1:0] x_in;
  logic [N*NW-1:0] n_in;
  logic [N-1:0]    gnt;
  logic [N-1:0]    done;
  logic [XW-1:0]   res;
  logic            busy;

  // Entry layout: [27:24] requester, [23:16] grant-to-done cycles, [15:0] result.
  logic [27:0] exp_q[$];

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          g_cyc    = 0;
  logic [N-1:0] prev_gnt = '0;
  int          last_idx = -1;
  bit          rot_mode = 1'b0;
  logic [27:0] mon_e;
  int          mon_idx;

  pow_arbiter #(.N(N), .XW(XW), .NW(NW)) dut (
    .clk  (clk),
    .nrst (nrst),
    .req  (req),
    .x_in (x_in),
    .n_in (n_in),
    .gnt  (gnt),
    .done (done),
    .res  (res),
    .busy (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [XW-1:0] pow_ref(input logic [XW-1:0] x, input int n);
    logic [XW-1:0] r;
    r = XW'(1);
    for (int i = 0; i < n; i++) r = r * x;
    return r;
  endfunction

  function automatic int steps_ref(input int n);
    int k;
    int m;
    k = 0;
    m = n;
    while (m != 0) begin
      if (m % 2 == 1) m = m - 1;
      else m = m / 2;
      k++;
    end
    return k;
  endfunction

  function automatic logic [27:0] mk_exp(input int i, input logic [XW-1:0] x, input int n);
    return {4'(i), 8'(3 + steps_ref(n)), pow_ref(x, n)};
  endfunction

  always @(negedge clk) begin
    if (gnt != '0 && prev_gnt == '0) g_cyc = cyc;
    prev_gnt = gnt;
    if (done != '0) begin
      mon_idx = -1;
      for (int i = 0; i < N; i++) if (done[i]) mon_idx = i;
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'(done), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("done_onehot", 32'(done), 32'd1 << mon_e[27:24]);
        check("gnt_at_done", 32'(gnt), 32'd1 << mon_e[27:24]);
        check("res", 32'(res), 32'(mon_e[15:0]));
        check("latency", 32'(cyc - g_cyc), 32'(mon_e[23:16]));
        if (rot_mode) check("rot_no_repeat", 32'(mon_idx == last_idx), 32'd0);
        last_idx = mon_idx;
      end
    end
  end

  task automatic reset_dut();
    nrst = 1'b0;
    req  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    nrst = 1'b1;
  endtask

  task automatic wait_done(input int i);
    bit seen;
    seen = 1'b0;
    for (int t = 0; t < 400; t++) begin
      @(negedge clk);
      if (done[i]) begin
        seen = 1'b1;
        break;
      end
    end
    check("done_seen", 32'(seen), 32'd1);
  endtask

  task automatic client(input int i, input int jobs, input logic [XW-1:0] x, input logic [NW-1:0] n);
    for (int j = 0; j < jobs; j++) begin
      x_in[i*XW +: XW] = x;
      n_in[i*NW +: NW] = n;
      req[i] = 1'b1;
      wait_done(i);
      @(posedge clk);
      #1 req[i] = 1'b0;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    bit seen;
    x_in = '0;
    n_in = '0;
    req  = '0;
    reset_dut();
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_res", 32'(res), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);

    // Single request, then wrap-around result and zero exponent.
    exp_q.push_back(mk_exp(0, 16'd3, 5));
    client(0, 1, 16'd3, 8'd5);
    exp_q.push_back(mk_exp(2, 16'd2, 16));
    client(2, 1, 16'd2, 8'd16);
    exp_q.push_back(mk_exp(1, 16'd7, 0));
    client(1, 1, 16'd7, 8'd0);

    req = '0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_gnt", 32'(gnt), 32'd0);
      check("idle_done", 32'(done), 32'd0);
      check("idle_start", 32'(dut.eng_start), 32'd0);
    end

    // Fairness: all four request together after reset, served 0..3.
    reset_dut();
    for (int i = 0; i < N; i++) exp_q.push_back(mk_exp(i, XW'(i + 2), 2));
    fork
      client(0, 1, 16'd2, 8'd2);
      client(1, 1, 16'd3, 8'd2);
      client(2, 1, 16'd4, 8'd2);
      client(3, 1, 16'd5, 8'd2);
    join

    // Rotation between requesters 0 and 3.
    reset_dut();
    rot_mode = 1'b1;
    last_idx = -1;
    for (int j = 0; j < 3; j++) begin
      exp_q.push_back(mk_exp(0, 16'd3, 3));
      exp_q.push_back(mk_exp(3, 16'd10, 4));
    end
    fork
      client(0, 3, 16'd3, 8'd3);
      client(3, 3, 16'd10, 8'd4);
    join
    rot_mode = 1'b0;

    // Reset in the middle of a long job: silent abort, then re-run.
    x_in[1*XW +: XW] = 16'd5;
    n_in[1*NW +: NW] = 8'd200;
    req[1] = 1'b1;
    seen = 1'b0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (gnt[1]) begin
        seen = 1'b1;
        break;
      end
    end
    check("mid_gnt_seen", 32'(seen), 32'd1);
    repeat (3) @(negedge clk);
    check("busy_before_reset", 32'(busy), 32'd1);
    #2 nrst = 1'b0;
    #1;
    check("mid_rst_gnt", 32'(gnt), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_res", 32'(res), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    req = '0;
    repeat (3) @(negedge clk);
    check("rst_hold_done", 32'(done), 32'd0);
    nrst = 1'b1;
    exp_q.push_back(mk_exp(1, 16'd5, 200));
    client(1, 1, 16'd5, 8'd200);

    repeat (5) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pow_arbiter.md
Name: pow_arbiter

Overview:
- Round-robin scheduler that shares one iterative square-and-multiply exponentiation engine (x^n mod 2^16) between N requesters.
- Each requester presents operands with a level request. The arbiter picks one requester, launches the shared engine, waits for completion, then returns the result with a one-cycle done pulse to the granted requester.
- Sits between client FSMs and the single power datapath instance, which it contains as a sub-module.

Parameters:
- N, 4, number of requesters (2..8)
- XW, 16, base/result width; all arithmetic is mod 2^XW
- NW, 8, exponent width

Ports:
- clk  in  1  system clock, all state on rising edge
- nrst  in  1  asynchronous active-low reset
- req  in  N  level request per requester; held until done seen
- x_in  in  N*XW  packed bases; requester i uses bits [i*XW +: XW]; stable while req[i]=1
- n_in  in  N*NW  packed exponents; requester i uses bits [i*NW +: NW]; stable while req[i]=1
- gnt  out  N  one-hot; high for granted requester from ISSUE through DONE
- done  out  N  one-hot one-cycle pulse; res valid for done[i]
- res  out  XW  registered result; holds last value
- busy  out  1  high in any state except IDLE

Behaviour:
- Reset (async, nrst=0): state=IDLE, ptr=0, sel=0, gnt=0, done=0, res=0, busy=0; engine returns to ready. Reset mid-operation aborts the job silently; no done is issued, and requesters re-request after reset.
- Arbiter FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE, req==0: stay in IDLE.
- IDLE, req!=0: sel = first i with req[i]=1, searching ptr, ptr+1, ... mod N. Go to ISSUE.
- ISSUE: engine start=1 (combinational, this cycle only). Engine operands are x_in/n_in slice[sel]. Go to WAIT.
- WAIT: stay while engine ready=0. When ready=1, res <= engine out and go to DONE. The engine's ready drops on the edge ending ISSUE, so WAIT never sees a stale ready.
- DONE: done[sel]=1. ptr <= (sel+1) mod N. Go to IDLE.
- gnt[sel]=1 in ISSUE, WAIT and DONE; otherwise 0.
- A requester drops req on the edge at which it sees done. If req[sel] is still high in the following IDLE, it has lowest priority because ptr has advanced. This guarantees no starvation: at most N-1 other jobs run between any two grants to the same requester.
- Requests arriving in ISSUE, WAIT or DONE are sampled only in IDLE.
- Latency: done is asserted in the cycle after edge E+3+k, where E is the IDLE edge that grants and k is the number of engine iteration steps. Each step: n even → x=x*x, n=n/2; n odd → a=a*x, n=n-1; a starts at 1. For n=0, k=0.
- Engine (sub-module):
  - ready=1 after reset. On start while ready: latch x, n; a=1; ready=0.
  - Each busy cycle: if n==0, out<=a and ready<=1; else perform one step.
  - Products are truncated to XW bits.
  - start while not ready is ignored; the arbiter never issues it.

Decomposition:
- Package pow_pkg: arbiter state enum (IDLE, ISSUE, WAIT, DONE); engine state constants READY/BUSY; localparam IW = $clog2(N).
- Sub-module pow_engine: ports clk, nrst, start, inx[XW], inn[NW], ready, out[XW]; implements the square-and-multiply engine described above.
- Round-robin pick is a combinational function inside pow_arbiter.

Test Plan:
- Single request: req[0], x=3, n=5 (k=4) → done[0] one cycle, res=243, 7 cycles after grant edge, gnt[0] high ISSUE..DONE.
- Wrap and zero exponent:
  - req[2], x=2, n=16 → res=0 (65536 mod 2^16).
  - Then req[1], x=7, n=0 → res=1, done 3 cycles after grant edge.
- Fairness: after reset, req=4'b1111 held, each requester drops req on its done. Operands: x=i+2, n=2. Required: done order 0,1,2,3; results 4, 9, 16, 25.
- Rotation: req[3] and req[0] always high, each re-asserting one cycle after its done. Required: grants alternate 3,0,3,0 once ptr passes 3; never two consecutive grants to the same requester.
- Reset mid-job: req[1], x=5, n=200; pull nrst low during WAIT. Required: immediately gnt=0, busy=0, res=0, no done pulse. After release, req[1] is re-granted and res = 5^200 mod 65536.
- Idle stability: req=0 for 20 cycles → busy=0, gnt=0, done=0, engine start never asserted.
